// File: rtl/fpu_align_ctrl.sv
// Operand alignment front end for a single-precision adder: compares, swaps and right-shifts
// the smaller extended mantissa over an IDLE/CMP/SHF/DONE handshake. Optional: FPU_ALIGN_STICKY_EN.
module fpu_align_ctrl #(
    parameter int unsigned SIZE_DATA  = 28,
    parameter int unsigned SIZE_SHIFT = 5
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_valid,
    output logic                  o_in_ready,
    input  logic [31:0]           i_a,
    input  logic [31:0]           i_b,
    output logic                  o_valid,
    input  logic                  i_out_ready,
    output logic [SIZE_DATA-1:0]  o_mant_big,
    output logic [SIZE_DATA-1:0]  o_mant_small,
    output logic [7:0]            o_exp,
    output logic                  o_sign_big,
    output logic                  o_sign_small,
    output logic                  o_swap,
    output logic                  o_special
);

    localparam logic [7:0] MaxShift = 8'(SIZE_DATA - 1);

    typedef enum logic [1:0] {StIdle, StCmp, StShf, StDone} state_e;

    state_e                state_q, state_d;
    logic [31:0]           a_q, a_d, b_q, b_d;
    logic [SIZE_SHIFT-1:0] shamt_q, shamt_d;
    logic [SIZE_DATA-1:0]  mant_big_q, mant_big_d, mant_small_q, mant_small_d;
    logic [7:0]            exp_q, exp_d;
    logic                  sign_big_q, sign_big_d, sign_small_q, sign_small_d;
    logic                  swap_q, swap_d, special_q, special_d;

    logic [7:0]            exp_a, exp_b, eff_a, eff_b, diff;
    logic [SIZE_DATA-1:0]  ext_a, ext_b, shifted;
    logic                  special_c, a_big;

    // Operand classification from the captured pair
    always_comb begin
        exp_a     = a_q[30:23];
        exp_b     = b_q[30:23];
        eff_a     = (exp_a != 8'd0) ? exp_a : 8'd1;
        eff_b     = (exp_b != 8'd0) ? exp_b : 8'd1;
        ext_a     = SIZE_DATA'({1'b0, exp_a != 8'd0, a_q[22:0], 3'b000});
        ext_b     = SIZE_DATA'({1'b0, exp_b != 8'd0, b_q[22:0], 3'b000});
        special_c = (exp_a == 8'hFF) || (exp_b == 8'hFF);
        a_big     = special_c || (eff_a > eff_b) || ((eff_a == eff_b) && (ext_a >= ext_b));
        diff      = a_big ? (eff_a - eff_b) : (eff_b - eff_a);
        if (special_c) begin
            diff = 8'd0;
        end else if (diff > MaxShift) begin
            diff = MaxShift;
        end
    end

    always_comb begin
        shifted = mant_small_q >> shamt_q;
`ifdef FPU_ALIGN_STICKY_EN
        // Any bit pushed past the LSB is folded into bit 0
        shifted[0] = shifted[0] | (|(mant_small_q & ~({SIZE_DATA{1'b1}} << shamt_q)));
`endif
    end

    always_comb begin
        state_d      = state_q;
        a_d          = a_q;
        b_d          = b_q;
        shamt_d      = shamt_q;
        mant_big_d   = mant_big_q;
        mant_small_d = mant_small_q;
        exp_d        = exp_q;
        sign_big_d   = sign_big_q;
        sign_small_d = sign_small_q;
        swap_d       = swap_q;
        special_d    = special_q;
        unique case (state_q)
            StIdle: begin
                if (i_valid) begin
                    a_d     = i_a;
                    b_d     = i_b;
                    state_d = StCmp;
                end
            end
            StCmp: begin
                swap_d       = !a_big;
                special_d    = special_c;
                shamt_d      = SIZE_SHIFT'(diff);
                mant_big_d   = a_big ? ext_a : ext_b;
                mant_small_d = a_big ? ext_b : ext_a;
                exp_d        = a_big ? eff_a : eff_b;
                sign_big_d   = a_big ? a_q[31] : b_q[31];
                sign_small_d = a_big ? b_q[31] : a_q[31];
                state_d      = StShf;
            end
            StShf: begin
                mant_small_d = shifted;
                state_d      = StDone;
            end
            StDone: begin
                if (i_out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q      <= StIdle;
            a_q          <= '0;
            b_q          <= '0;
            shamt_q      <= '0;
            mant_big_q   <= '0;
            mant_small_q <= '0;
            exp_q        <= '0;
            sign_big_q   <= 1'b0;
            sign_small_q <= 1'b0;
            swap_q       <= 1'b0;
            special_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            a_q          <= a_d;
            b_q          <= b_d;
            shamt_q      <= shamt_d;
            mant_big_q   <= mant_big_d;
            mant_small_q <= mant_small_d;
            exp_q        <= exp_d;
            sign_big_q   <= sign_big_d;
            sign_small_q <= sign_small_d;
            swap_q       <= swap_d;
            special_q    <= special_d;
        end
    end

    assign o_in_ready   = (state_q == StIdle);
    assign o_valid      = (state_q == StDone);
    assign o_mant_big   = mant_big_q;
    assign o_mant_small = mant_small_q;
    assign o_exp        = exp_q;
    assign o_sign_big   = sign_big_q;
    assign o_sign_small = sign_small_q;
    assign o_swap       = swap_q;
    assign o_special    = special_q;

endmodule

// File: tb/tb_fpu_align_ctrl.sv
// Scoreboard bench for fpu_align_ctrl: stimulus pushes expected results, a negedge monitor pops
// and compares, and also watches latency, hold stability and reset behaviour.
module tb_fpu_align_ctrl;

    typedef struct packed {
        logic [27:0] mb;
        logic [27:0] ms;
        logic [7:0]  e;
        logic        sb;
        logic        ss;
        logic        sw;
        logic        sp;
    } res_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        i_valid = 1'b0;
    logic        i_out_ready = 1'b0;
    logic [31:0] i_a = '0;
    logic [31:0] i_b = '0;
    logic        o_in_ready, o_valid, o_sign_big, o_sign_small, o_swap, o_special;
    logic [27:0] o_mant_big, o_mant_small;
    logic [7:0]  o_exp;

    int   n_checks = 0;
    int   n_pass = 0;
    int   rdy_mode = 2;  // 0 random, 1 held low, 2 held high
    res_t exp_q[$];

    fpu_align_ctrl dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_valid      (i_valid),
        .o_in_ready   (o_in_ready),
        .i_a          (i_a),
        .i_b          (i_b),
        .o_valid      (o_valid),
        .i_out_ready  (i_out_ready),
        .o_mant_big   (o_mant_big),
        .o_mant_small (o_mant_small),
        .o_exp        (o_exp),
        .o_sign_big   (o_sign_big),
        .o_sign_small (o_sign_small),
        .o_swap       (o_swap),
        .o_special    (o_special)
    );

    always #5 clk = ~clk;

    task automatic check(input bit ok, input string name, input string msg);
        n_checks++;
        if (ok) n_pass++;
        else $display("FAIL %s: %s", name, msg);
    endtask

    function automatic res_t cur_out();
        res_t r;
        r = {o_mant_big, o_mant_small, o_exp, o_sign_big, o_sign_small, o_swap, o_special};
        return r;
    endfunction

    // Reference: alignment computed directly from the IEEE fields with integer arithmetic
    function automatic res_t model(input logic [31:0] a, input logic [31:0] b);
        int unsigned ea, eb, effa, effb, ma, mb, mbig, msml, ebig, esml, d, sm;
        bit spc, abig;
        res_t r;
        ea   = 32'(a[30:23]);
        eb   = 32'(b[30:23]);
        effa = (ea == 0) ? 1 : ea;
        effb = (eb == 0) ? 1 : eb;
        ma   = ((ea != 0) ? 32'h0400_0000 : 0) + 32'(a[22:0]) * 8;
        mb   = ((eb != 0) ? 32'h0400_0000 : 0) + 32'(b[22:0]) * 8;
        spc  = (ea == 255) || (eb == 255);
        abig = spc || (effa > effb) || (effa == effb && ma >= mb);
        mbig = abig ? ma : mb;
        msml = abig ? mb : ma;
        ebig = abig ? effa : effb;
        esml = abig ? effb : effa;
        d    = spc ? 0 : ebig - esml;
        if (d > 27) d = 27;
        sm = msml >> d;
`ifdef FPU_ALIGN_STICKY_EN
        if ((msml % (32'd1 << d)) != 0) sm = sm | 1;
`endif
        r.mb = mbig[27:0];
        r.ms = sm[27:0];
        r.e  = ebig[7:0];
        r.sb = abig ? a[31] : b[31];
        r.ss = abig ? b[31] : a[31];
        r.sw = !abig;
        r.sp = spc;
        return r;
    endfunction

    function automatic res_t mk(input logic [27:0] mb, input logic [27:0] ms, input logic [7:0] e,
                                input logic sw);
        res_t r;
        r = '{mb: mb, ms: ms, e: e, sb: 1'b0, ss: 1'b0, sw: sw, sp: 1'b0};
        return r;
    endfunction

    // Called at posedge+1
    task automatic send(input logic [31:0] a, input logic [31:0] b, input res_t e);
        int n = 0;
        while (!o_in_ready && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!o_in_ready) begin
            check(1'b0, "in_ready_timeout", "got in_ready=0 want 1 within 50 cycles");
            return;
        end
        i_valid = 1'b1;
        i_a     = a;
        i_b     = b;
        @(posedge clk);
        exp_q.push_back(e);
        #1;
        i_valid = 1'b0;
    endtask

    task automatic send_rand();
        logic [31:0] a, b;
        logic [7:0]  ex;
        a = $urandom;
        b = $urandom;
        case ($urandom_range(0, 6))
            0: b[30:23] = a[30:23];
            1: begin ex = a[30:23] + 8'($urandom_range(0, 30)); b[30:23] = ex; end
            2: a[30:23] = 8'h00;
            3: b[30:23] = 8'hFF;
            4: begin b = a; b[0] = ~a[0]; end
            5: begin a[30:23] = 8'h00; b[30:23] = 8'h00; end
            default: ;
        endcase
        send(a, b, model(a, b));
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 300) begin
            @(posedge clk);
            #1;
            n++;
        end
        check(exp_q.size() == 0, "drain", $sformatf("got %0d pending want 0", exp_q.size()));
    endtask

    task automatic check_reset_outputs(input string name);
        check(!o_valid && o_in_ready && cur_out() == '0, name,
              $sformatf("got valid=%0b in_ready=%0b data=%h want 0/1/0",
                        o_valid, o_in_ready, cur_out()));
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0: i_out_ready = 1'($urandom_range(0, 1));
                1: i_out_ready = 1'b0;
                default: i_out_ready = 1'b1;
            endcase
        end
    end

    // Monitor
    initial begin
        bit   prev_v = 1'b0;
        bit   prev_taken = 1'b0;
        int   since = 100;
        res_t snap = '0;
        res_t got, want;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_v = 1'b0;
                since  = 100;
            end else begin
                if (o_in_ready && i_valid) since = 0;
                else if (since < 100) since++;
                got = cur_out();
                if (o_valid && !prev_v)
                    check(since == 3, "latency", $sformatf("got %0d want 3 cycles", since));
                if (o_valid && prev_v && !prev_taken)
                    check(got == snap && !o_in_ready, "hold_stable",
                          $sformatf("got %h in_ready=%0b want %h in_ready=0",
                                    got, o_in_ready, snap));
                if (o_valid && i_out_ready) begin
                    if (exp_q.size() == 0) begin
                        check(1'b0, "unexpected_valid", $sformatf("got %h want no output", got));
                    end else begin
                        want = exp_q.pop_front();
                        check(got == want, "result", $sformatf("got %h want %h", got, want));
                    end
                end
                snap       = got;
                prev_v     = o_valid;
                prev_taken = o_valid && i_out_ready;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish want finish before timeout");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset_during");
        rst = 1'b0;
        @(posedge clk);
        #1;
        check_reset_outputs("reset_after");

        send(32'h4000_0000, 32'h3F80_0000, mk(28'h400_0000, 28'h200_0000, 8'h80, 1'b0));
        send(32'h3F80_0000, 32'h4120_0000, mk(28'h500_0000, 28'h080_0000, 8'h82, 1'b1));
`ifdef FPU_ALIGN_STICKY_EN
        send(32'h4B80_0000, 32'h3F80_0001, mk(28'h400_0000, 28'h000_0005, 8'h97, 1'b0));
        send(32'h6400_0000, 32'h3F80_0000, mk(28'h400_0000, 28'h000_0001, 8'hC8, 1'b0));
`else
        send(32'h4B80_0000, 32'h3F80_0001, mk(28'h400_0000, 28'h000_0004, 8'h97, 1'b0));
        send(32'h6400_0000, 32'h3F80_0000, mk(28'h400_0000, 28'h000_0000, 8'hC8, 1'b0));
`endif
        drain();

        rdy_mode = 0;
        repeat (60) send_rand();
        drain();

        // Back-pressure: hold the result in DONE for 5 cycles
        rdy_mode = 1;
        send(32'hC0A0_0000, 32'h4040_0000, model(32'hC0A0_0000, 32'h4040_0000));
        n = 0;
        while (!o_valid && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        check(o_valid, "hold_reach_done", $sformatf("got valid=%0b want 1", o_valid));
        repeat (5) @(posedge clk);
        #1;
        rdy_mode = 2;
        drain();

        // Reset while the next pair is in SHF
        send(32'h4100_0000, 32'h3F00_0000, model(32'h4100_0000, 32'h3F00_0000));
        @(posedge clk);
        #1;
        rst = 1'b1;
        exp_q.delete();
        #1;
        check_reset_outputs("reset_mid_shf");
        @(posedge clk);
        #1;
        rst = 1'b0;
        n = 0;
        repeat (6) begin
            @(posedge clk);
            #1;
            if (o_valid) n++;
        end
        check(n == 0, "discarded_pair", $sformatf("got %0d valid cycles want 0", n));

        send(32'h3F80_0000, 32'h3F80_0000, model(32'h3F80_0000, 32'h3F80_0000));
        drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/fpu_align_ctrl.md
FPU_ALIGN_CTRL -- requirements
Module: fpu_align_ctrl

Interface
REQ-001 Parameter SIZE_DATA, default 28, is the extended-mantissa width fed to the right shifter.
REQ-002 Parameter SIZE_SHIFT, default 5, is the shifter amount width.
REQ-003 i_clk  input  1  sole clock; all state updates on rising edge.
REQ-004 i_rst  input  1  reset; asynchronous, active-high.
REQ-005 i_valid  input  1  operand pair valid.
REQ-006 o_in_ready  output  1  block can accept an operand pair.
REQ-007 i_a, i_b  input  32 each  IEEE-754 single-precision operands.
REQ-008 o_valid  output  1  aligned result valid.
REQ-009 i_out_ready  input  1  downstream accepts the result.
REQ-010 o_mant_big, o_mant_small  output  SIZE_DATA each  aligned extended mantissas.
REQ-011 o_exp  output  8  result exponent, which is the larger effective exponent.
REQ-012 o_sign_big, o_sign_small  output  1 each  operand signs after swap.
REQ-013 o_swap  output  1  B was selected as the big operand.
REQ-014 o_special  output  1  either operand has exponent 0xFF.

Function
REQ-015 States are IDLE, CMP, SHF and DONE; o_in_ready = (state == IDLE); o_valid = (state == DONE).
REQ-016 IDLE & i_valid captures i_a and i_b and moves to CMP; otherwise the block stays in IDLE.
REQ-017 CMP registers the swap, the exponent difference and the unshifted extended mantissas, then moves to SHF unconditionally.
REQ-018 SHF registers the shifted small mantissa and the sticky bit, then moves to DONE unconditionally.
REQ-019 DONE & i_out_ready moves to IDLE; all outputs hold stable while DONE & !i_out_ready.
REQ-020 Latency: o_valid rises 3 cycles after the accept edge; a new pair cannot be accepted in the same cycle a result is consumed, so maximum throughput is 1 pair per 4 cycles.
REQ-021 Effective exponent = exp if exp != 0, else 1; hidden bit = (exp != 0).
REQ-022 Extended mantissa = {1'b0, hidden, frac[22:0], 3'b000}, 28 bits.
REQ-023 Big operand is A if eff_exp_a > eff_exp_b, or if the exponents are equal and mant_a >= mant_b; otherwise B, with o_swap = 1.
REQ-024 Shift amount = min(eff_exp_big - eff_exp_small, 27), presented to a SIZE_SHIFT-bit logical right shifter that fills with zeros.
REQ-025 o_special = 1 forces shift amount 0 and no swap; fields pass through unmodified.
REQ-026 o_exp = exponent field of the big operand, or eff_exp_big when that field is 0.

Reset
REQ-027 i_rst forces state IDLE immediately, in any state including mid-CMP or mid-SHF; an in-flight pair is discarded.
REQ-028 Reset values: o_valid = 0, o_in_ready = 1 one cycle after release, and all data outputs = 0.

Configuration
REQ-029 With macro FPU_ALIGN_STICKY_EN defined, o_mant_small[0] = shifted bit 0 OR'd with all bits shifted out.
REQ-030 With FPU_ALIGN_STICKY_EN undefined, o_mant_small is the plain truncated shift and no sticky logic is present.

Verification
REQ-031 A=0x40000000, B=0x3F800000 -> o_exp=0x80, o_swap=0, o_mant_big=0x4000000, o_mant_small=0x2000000, o_valid 3 cycles after accept.
REQ-032 A=0x3F800000, B=0x41200000 -> o_swap=1, o_exp=0x82, o_mant_big=0x5000000, o_mant_small=0x0800000.
REQ-033 A=0x4B800000, B=0x3F800001 (difference 24) -> o_mant_small=0x0000005 with FPU_ALIGN_STICKY_EN, 0x0000004 without.
REQ-034 A=0x64000000, B=0x3F800000 (difference 73, clamped to 27) -> o_mant_small=0x0000001 with the macro, 0x0000000 without.
REQ-035 Hold i_out_ready=0 for 5 cycles in DONE -> outputs stable, o_in_ready=0; then pulse i_rst during SHF of the next pair -> IDLE, o_valid never asserted for that pair.
